// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and helpers for the register-file write arbiter: FSM encoding,
// requester indices, default sizes and the address decoder.
package regfile_write_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArb,
        StClear,
        StDone
    } rf_state_e;

    localparam int unsigned REQ_CPU = 0;
    localparam int unsigned REQ_IRQ = 1;
    localparam int unsigned REQ_DBG = 2;

    localparam int unsigned DefaultNrOfBits = 32;
    localparam int unsigned DefaultNrOfRegs = 32;

    // Upper bound on register count supported by the decoder; callers truncate
    // the result to their own NrOfRegs.
    localparam int unsigned MaxRegs = 1024;

    // Register 0 is hard-wired to zero and out-of-range addresses decode to nothing.
    function automatic logic [MaxRegs-1:0] addr_to_onehot(input logic [31:0] addr,
                                                          input int unsigned nr_regs);
        logic [MaxRegs-1:0] onehot;
        onehot = '0;
        if (addr != 32'd0 && addr < nr_regs && addr < MaxRegs) begin
            onehot = {{(MaxRegs - 1){1'b0}}, 1'b1} << addr;
        end
        return onehot;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Three-way round-robin priority picker: the requester after the last granted
// one has highest priority.
module rr_arbiter3
    import regfile_write_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [2:0] last_grant,
    output logic [2:0] grant
);

    always_comb begin
        grant = 3'b000;
        case (last_grant)
            3'b001: begin
                if (req[REQ_IRQ])      grant = 3'b010;
                else if (req[REQ_DBG]) grant = 3'b100;
                else if (req[REQ_CPU]) grant = 3'b001;
            end
            3'b010: begin
                if (req[REQ_DBG])      grant = 3'b100;
                else if (req[REQ_CPU]) grant = 3'b001;
                else if (req[REQ_IRQ]) grant = 3'b010;
            end
            // 3'b100 and the reset value: requester 0 first.
            default: begin
                if (req[REQ_CPU])      grant = 3'b001;
                else if (req[REQ_IRQ]) grant = 3'b010;
                else if (req[REQ_DBG]) grant = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates three write ports onto a single register-file write strobe and
// provides a sequenced clear of registers 1..NrOfRegs-1.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned NrOfBits = DefaultNrOfBits,
    parameter int unsigned NrOfRegs = DefaultNrOfRegs,
    localparam int unsigned AddrBits = $clog2(NrOfRegs)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [2:0]            req,
    input  logic [3*AddrBits-1:0] addr,
    input  logic [3*NrOfBits-1:0] data,
    output logic [2:0]            grant,
    output logic [NrOfRegs-1:0]   wr_en,
    output logic [NrOfBits-1:0]   wr_data,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done
);

    rf_state_e             state_q;
    logic [2:0]            last_grant_q;
    logic [2:0]            rr_grant;
    logic [AddrBits-1:0]   clr_cnt_q;
    logic [AddrBits-1:0]   sel_addr;
    logic [NrOfBits-1:0]   sel_data;
    logic [NrOfRegs-1:0]   wr_en_q;
    logic [NrOfBits-1:0]   wr_data_q;
    logic                  clr_busy_q;
    logic                  clr_done_q;
    logic                  arb_phase;

    rr_arbiter3 u_rr (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (rr_grant)
    );

    assign arb_phase = (state_q == StIdle) || (state_q == StArb);
    // Grant is combinational, but never while a synchronous reset is pending.
    assign grant     = (arb_phase && !Reset) ? rr_grant : 3'b000;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        case (grant)
            3'b001: begin
                sel_addr = addr[REQ_CPU*AddrBits +: AddrBits];
                sel_data = data[REQ_CPU*NrOfBits +: NrOfBits];
            end
            3'b010: begin
                sel_addr = addr[REQ_IRQ*AddrBits +: AddrBits];
                sel_data = data[REQ_IRQ*NrOfBits +: NrOfBits];
            end
            3'b100: begin
                sel_addr = addr[REQ_DBG*AddrBits +: AddrBits];
                sel_data = data[REQ_DBG*NrOfBits +: NrOfBits];
            end
            default: ;
        endcase
    end

    // Outputs are registered, so busy/done trail the state by one cycle and
    // line up with the write strobes the state issued.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= StIdle;
            last_grant_q <= 3'b100;
            clr_cnt_q    <= '0;
            wr_en_q      <= '0;
            wr_data_q    <= '0;
            clr_busy_q   <= 1'b0;
            clr_done_q   <= 1'b0;
        end else begin
            clr_busy_q <= (state_q == StClear);
            clr_done_q <= (state_q == StDone);
            wr_en_q    <= '0;
            case (state_q)
                StIdle, StArb: begin
                    if (|grant) begin
                        wr_en_q      <= NrOfRegs'(addr_to_onehot(32'(sel_addr), NrOfRegs));
                        wr_data_q    <= sel_data;
                        last_grant_q <= grant;
                    end
                    if (clr_start) begin
                        state_q   <= StClear;
                        clr_cnt_q <= AddrBits'(1);
                    end else begin
                        state_q <= (|req) ? StArb : StIdle;
                    end
                end
                StClear: begin
                    wr_en_q   <= NrOfRegs'(addr_to_onehot(32'(clr_cnt_q), NrOfRegs));
                    wr_data_q <= '0;
                    if (clr_cnt_q == AddrBits'(NrOfRegs - 1)) begin
                        state_q   <= StDone;
                        clr_cnt_q <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + AddrBits'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_data  = wr_data_q;
    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic,
// compared each cycle against a behavioural model of the arbiter.
module tb_regfile_write_arbiter;

    localparam int unsigned NB  = 32;
    localparam int unsigned NR  = 32;
    localparam int unsigned NRS = 24;
    localparam int unsigned AB  = 5;

    logic            Clock = 1'b0;
    logic            Reset;
    logic [2:0]      req;
    logic [3*AB-1:0] addr;
    logic [3*NB-1:0] data;
    logic            clr_start;
    logic [2:0]      grant,   grant_s;
    logic [NR-1:0]   wr_en;
    logic [NRS-1:0]  wr_en_s;
    logic [NB-1:0]   wr_data, wr_data_s;
    logic            clr_busy, clr_done, clr_busy_s, clr_done_s;

    regfile_write_arbiter #(.NrOfBits(NB), .NrOfRegs(NR)) dut (
        .Clock(Clock), .Reset(Reset), .req(req), .addr(addr), .data(data),
        .grant(grant), .wr_en(wr_en), .wr_data(wr_data), .clr_start(clr_start),
        .clr_busy(clr_busy), .clr_done(clr_done)
    );

    // Smaller register file sharing the inputs; exercises out-of-range addresses.
    regfile_write_arbiter #(.NrOfBits(NB), .NrOfRegs(NRS)) dut_s (
        .Clock(Clock), .Reset(Reset), .req(req), .addr(addr), .data(data),
        .grant(grant_s), .wr_en(wr_en_s), .wr_data(wr_data_s), .clr_start(1'b0),
        .clr_busy(clr_busy_s), .clr_done(clr_done_s)
    );

    always #5 Clock = ~Clock;

    // Model: mode 0 = arbitrating, 1 = clearing, 2 = clear finished.
    int          m_mode, m_ptr, m_reg;
    logic [2:0]  e_grant;
    logic [31:0] e_wr_en, e_wr_data;
    logic [23:0] e_wr_en_s;
    logic        e_busy, e_done;
    bit          sync;
    int          total, bad, busy_cnt, done_cnt;
    logic [2:0]  obs_grant;
    logic [31:0] obs_wr_en, obs_wr_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] model_grant();
        logic [2:0] g;
        g = '0;
        if (Reset || m_mode != 0) return g;
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (m_ptr + k) % 3;
            if (req[i]) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ptr = 0; m_reg = 0;
        e_wr_en = '0; e_wr_en_s = '0; e_wr_data = '0; e_busy = 0; e_done = 0;
    endtask

    task automatic model_edge();
        int g, ai;
        if (Reset) begin
            model_reset();
            return;
        end
        g = -1;
        for (int i = 0; i < 3; i++) if (e_grant[i]) g = i;
        e_busy = (m_mode == 1);
        e_done = (m_mode == 2);
        e_wr_en = '0;
        e_wr_en_s = '0;
        case (m_mode)
            0: begin
                if (g >= 0) begin
                    ai = int'(addr[g*AB +: AB]);
                    if (ai != 0 && ai < NR)  e_wr_en[ai] = 1'b1;
                    if (ai != 0 && ai < NRS) e_wr_en_s[ai] = 1'b1;
                    e_wr_data = data[g*NB +: NB];
                    m_ptr = (g + 1) % 3;
                end
                if (clr_start) begin
                    m_mode = 1;
                    m_reg = 1;
                end
            end
            1: begin
                e_wr_en[m_reg] = 1'b1;
                e_wr_data = '0;
                if (m_reg == NR - 1) m_mode = 2;
                else m_reg++;
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic cycle();
        @(negedge Clock);
        e_grant = model_grant();
        obs_grant = grant; obs_wr_en = wr_en; obs_wr_data = wr_data;
        chk("grant", grant, e_grant);
        chk("wr_en", wr_en, e_wr_en);
        chk("wr_data", wr_data, e_wr_data);
        chk("clr_busy", clr_busy, e_busy);
        chk("clr_done", clr_done, e_done);
        if (sync) begin
            chk("small_grant", grant_s, e_grant);
            chk("small_wr_en", wr_en_s, e_wr_en_s);
            chk("small_wr_data", wr_data_s, e_wr_data);
        end
        if (clr_busy === 1'b1) busy_cnt++;
        if (clr_done === 1'b1) done_cnt++;
        model_edge();
        @(posedge Clock);
        #1;
    endtask

    // Requesters keep req/addr/data until granted, then may pick new values.
    task automatic drive_random(input int unsigned pct, input int unsigned clr_pct);
        for (int i = 0; i < 3; i++) begin
            if (!req[i] || e_grant[i]) begin
                req[i] = ($urandom_range(99) < pct);
                addr[i*AB +: AB] = 5'($urandom_range(31));
                data[i*NB +: NB] = $urandom;
            end
        end
        clr_start = ($urandom_range(99) < clr_pct);
    endtask

    initial begin
        total = 0; bad = 0; busy_cnt = 0; done_cnt = 0; sync = 1;
        Reset = 1'b1; clr_start = 1'b0; req = 3'b111;
        addr = {5'd26, 5'd9, 5'd3};
        data = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        e_grant = '0;
        @(posedge Clock);
        #1;
        model_reset();

        // Reset with all requesters active, then the rotation.
        cycle();
        cycle();
        Reset = 1'b0;
        cycle(); chk("seq0", obs_grant, 3'b001);
        cycle(); chk("seq1", obs_grant, 3'b010); chk("a0_write", obs_wr_en, 32'h0000_0008);
        cycle(); chk("seq2", obs_grant, 3'b100);
        cycle(); chk("seq3", obs_grant, 3'b001);
        req = 3'b000;
        cycle();
        cycle();

        // Write to the zero register, then to an address valid only in the big file.
        req = 3'b001; addr[4:0] = 5'd0; data[31:0] = 32'hDEAD;
        cycle(); chk("zero_grant", obs_grant, 3'b001);
        req = 3'b000;
        cycle(); chk("zero_wr_en", obs_wr_en, 32'h0); chk("zero_data", obs_wr_data, 32'hDEAD);
        req = 3'b001; addr[4:0] = 5'd27; data[31:0] = $urandom;
        cycle();
        req = 3'b000;
        cycle();
        sync = 0;

        repeat (40) begin drive_random(60, 0); cycle(); end
        req = 3'b000; clr_start = 1'b0;
        cycle();

        // Full clear from idle, with a redundant clr_start mid-clear.
        busy_cnt = 0; done_cnt = 0;
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        repeat (14) cycle();
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        repeat (19) cycle();
        chk("busy_len", busy_cnt, 31);
        chk("done_len", done_cnt, 1);

        // Same-cycle request and clear; a request raised during the clear waits.
        req = 3'b001; addr[4:0] = 5'd5; data[31:0] = 32'h1234; clr_start = 1'b1;
        cycle(); chk("clr_req_grant", obs_grant, 3'b001);
        req = 3'b000; clr_start = 1'b0;
        cycle(); chk("clr_req_wr_en", obs_wr_en, 32'h0000_0020);
        chk("clr_req_data", obs_wr_data, 32'h1234);
        req = 3'b010; addr[9:5] = 5'd12; data[63:32] = $urandom;
        repeat (31) cycle();
        chk("stall_in_done", obs_grant, 3'b000);
        cycle(); chk("irq_after_done", obs_grant, 3'b010);
        req = 3'b000;
        cycle();
        cycle();

        // Reset on the 10th clear cycle aborts without a done pulse.
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        repeat (9) cycle();
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        req = 3'b010; addr[9:5] = 5'd7; data[63:32] = $urandom;
        cycle(); chk("abort_grant", obs_grant, 3'b010);
        req = 3'b000;
        repeat (35) cycle();
        chk("abort_no_done", done_cnt, 0);
        chk("abort_no_busy", busy_cnt, 0);

        repeat (400) begin drive_random(50, 3); cycle(); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
